trap_csr_file: RTL and testbench

Machine-mode CSR file with trap entry/exit sequencing, sitting directly downstream of the exception unit in the MEM/WB boundary. Executes CSRRW/S/C accesses, commits trap state (mepc/mcause/mtval/mstatus) on exceptions and interrupts, restores state on MRET, and returns the redirect PC through a valid/ack handshake. Also provides the mcycle/minstret counters and a registered pending-interrupt indication back to the exception logic.

---
 rtl/trap_csr_if.sv | 39 +++
 rtl/trap_csr_file.sv | 207 ++++++++++++++++++++
 tb/tb_trap_csr_file.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_csr_if.sv
// Handshake/bus bundle between the exception unit, fetch redirect and the machine-mode CSR file.
interface trap_csr_if;
    logic        csr_w;
    logic [1:0]  csr_wsc_mode;
    logic [11:0] csr_raddr;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic        irq_ext;
    logic        instret_inc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic        busy;
    logic        irq_pending;
    logic [31:0] mstatus_out;

    modport master (
        output csr_w, csr_wsc_mode, csr_raddr, csr_waddr, csr_wdata,
        output trap_req, trap_cause, trap_epc, trap_tval, mret_req,
        output irq_ext, instret_inc, redirect_ack,
        input  csr_rdata, csr_illegal, redirect_valid, redirect_pc,
        input  busy, irq_pending, mstatus_out
    );

    modport slave (
        input  csr_w, csr_wsc_mode, csr_raddr, csr_waddr, csr_wdata,
        input  trap_req, trap_cause, trap_epc, trap_tval, mret_req,
        input  irq_ext, instret_inc, redirect_ack,
        output csr_rdata, csr_illegal, redirect_valid, redirect_pc,
        output busy, irq_pending, mstatus_out
    );
endinterface

// File: rtl/trap_csr_file.sv
// Machine-mode CSR file with trap entry / MRET sequencing and redirect handshake.
// Optional macro VECTORED_MTVEC_EN enables vectored mtvec mode for interrupts.
module trap_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic       clk,
    input  logic       rst,
    trap_csr_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 64;
    localparam logic [XLEN-1:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [XLEN-1:0] MIE_MASK      = 32'h0000_0888;
`ifdef VECTORED_MTVEC_EN
    localparam logic [XLEN-1:0] MTVEC_MASK    = 32'hFFFF_FFFF;
`else
    localparam logic [XLEN-1:0] MTVEC_MASK    = 32'hFFFF_FFFC;
`endif

    typedef enum logic [1:0] {S_IDLE, S_TRAP, S_MRET, S_REDIR} state_t;

    state_t          state, state_d;
    logic            st_mie, st_mpie;
    logic [XLEN-1:0] mie_r, mtvec, mscratch, mepc, mcause, mtval;
    logic [CW-1:0]   mcycle, minstret;
    logic [XLEN-1:2] lat_epc;
    logic [XLEN-1:0] lat_cause, lat_tval;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            busy_q, irq_pending_q, latch_trap;
    logic [XLEN-1:0] mstatus_val, old_val, new_val, mtvec_base, trap_target;
    logic            impl, read_only, wr_en;

    assign mstatus_val = MSTATUS_FIXED | {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mtvec_base  = {mtvec[XLEN-1:2], 2'b00};

    function automatic logic [XLEN-1:0] csr_read(input logic [11:0] addr);
        logic [XLEN-1:0] val;
        case (addr)
            12'h300: val = mstatus_val;
            12'h301: val = MISA_VAL;
            12'h304: val = mie_r;
            12'h305: val = mtvec;
            12'h340: val = mscratch;
            12'h341: val = mepc;
            12'h342: val = mcause;
            12'h343: val = mtval;
            12'h344: val = {20'b0, bus.irq_ext, 11'b0};
            12'hB00: val = mcycle[31:0];
            12'hB80: val = mcycle[63:32];
            12'hB02: val = minstret[31:0];
            12'hB82: val = minstret[63:32];
            default: val = '0;
        endcase
        return val;
    endfunction

    // Write-side decode: unimplemented or read-only targets are illegal.
    always_comb begin
        impl      = 1'b1;
        read_only = 1'b0;
        case (bus.csr_waddr)
            12'h301, 12'h344: read_only = 1'b1;
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'hB00, 12'hB80, 12'hB02, 12'hB82: impl = 1'b1;
            default: impl = 1'b0;
        endcase
    end

    assign bus.csr_illegal = bus.csr_w && (!impl || read_only);
    assign bus.csr_rdata   = csr_read(bus.csr_raddr);

    always_comb begin
        old_val = csr_read(bus.csr_waddr);
        case (bus.csr_wsc_mode)
            2'b01:   new_val = bus.csr_wdata;
            2'b10:   new_val = old_val | bus.csr_wdata;
            2'b11:   new_val = old_val & ~bus.csr_wdata;
            default: new_val = old_val;
        endcase
    end

    // A CSR access colliding with an accepted trap/MRET request is dropped.
    assign wr_en = bus.csr_w && (bus.csr_wsc_mode != 2'b00) && !bus.csr_illegal &&
                   (state == S_IDLE) && !bus.trap_req && !bus.mret_req;

`ifdef VECTORED_MTVEC_EN
    assign trap_target = (mtvec[1:0] == 2'b01 && lat_cause[31]) ?
                         mtvec_base + {lat_cause[29:0], 2'b00} : mtvec_base;
`else
    assign trap_target = mtvec_base;
`endif

    always_comb begin
        state_d          = state;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        latch_trap       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.trap_req) begin
                    state_d    = S_TRAP;
                    latch_trap = 1'b1;
                end else if (bus.mret_req) begin
                    state_d = S_MRET;
                end
            end
            S_TRAP: begin
                state_d          = S_REDIR;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = trap_target;
            end
            S_MRET: begin
                state_d          = S_REDIR;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mepc;
            end
            S_REDIR: begin
                if (bus.redirect_ack) begin
                    state_d          = S_IDLE;
                    redirect_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
            lat_epc          <= '0;
            lat_cause        <= '0;
            lat_tval         <= '0;
        end else begin
            state            <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            busy_q           <= (state_d != S_IDLE);
            if (latch_trap) begin
                lat_epc   <= bus.trap_epc[XLEN-1:2];
                lat_cause <= bus.trap_cause;
                lat_tval  <= bus.trap_tval;
            end
        end
    end

    // CSR state: writes only happen in IDLE, so they never collide with trap/MRET commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie        <= 1'b0;
            st_mpie       <= 1'b0;
            mie_r         <= '0;
            mtvec         <= MTVEC_RESET & MTVEC_MASK;
            mscratch      <= '0;
            mepc          <= '0;
            mcause        <= '0;
            mtval         <= '0;
            mcycle        <= '0;
            minstret      <= '0;
            irq_pending_q <= 1'b0;
        end else begin
            irq_pending_q <= st_mie & mie_r[11] & bus.irq_ext;
            mcycle        <= mcycle + CW'(1);
            if (bus.instret_inc) minstret <= minstret + CW'(1);
            if (wr_en) begin
                case (bus.csr_waddr)
                    12'h300: begin
                        st_mie  <= new_val[3];
                        st_mpie <= new_val[7];
                    end
                    12'h304: mie_r    <= new_val & MIE_MASK;
                    12'h305: mtvec    <= new_val & MTVEC_MASK;
                    12'h340: mscratch <= new_val;
                    12'h341: mepc     <= {new_val[XLEN-1:2], 2'b00};
                    12'h342: mcause   <= new_val;
                    12'h343: mtval    <= new_val;
                    12'hB00: mcycle   <= {mcycle[63:32], new_val};
                    12'hB80: mcycle   <= {new_val, mcycle[31:0]};
                    12'hB02: minstret <= {minstret[63:32], new_val};
                    12'hB82: minstret <= {new_val, minstret[31:0]};
                    default: ;
                endcase
            end
            if (state == S_TRAP) begin
                mepc    <= {lat_epc, 2'b00};
                mcause  <= lat_cause;
                mtval   <= lat_tval;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end
            if (state == S_MRET) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = busy_q;
    assign bus.irq_pending    = irq_pending_q;
    assign bus.mstatus_out    = mstatus_val;
endmodule

// File: tb/tb_trap_csr_file.sv
// Scoreboard bench for trap_csr_file: randomized CSR/trap traffic against a transaction-level model.
module tb_trap_csr_file;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0000;
    localparam logic [31:0] MISA      = 32'h4000_0100;
`ifdef VECTORED_MTVEC_EN
    localparam logic [31:0] M_TVEC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] M_TVEC_MASK = 32'hFFFF_FFFC;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_csr_if bus();
    trap_csr_file #(.MTVEC_RESET(MTVEC_RST), .MISA_VAL(MISA)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    logic        m_mie_b, m_mpie_b, m_irqp;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret;
    bit          m_busy;

    logic [31:0] pc_q[$];
    logic [31:0] rd_exp_q[$];
    logic [11:0] rd_addr_q[$];
    bit          rd_chk;
    logic [31:0] last_redirect_pc;
    logic [11:0] mon_addr;
    logic [31:0] mon_exp;

    logic [11:0] wlist [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h301};
    logic [11:0] rlist [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                12'hB82, 12'h7C0, 12'h000, 12'hF11};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_mstatus();
        return 32'h0000_1800 | (32'(m_mpie_b) << 7) | (32'(m_mie_b) << 3);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus();
            12'h301: return MISA;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return 32'(bus.irq_ext) << 11;
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_writable(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic logic [31:0] m_trap_target(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] base;
        base = tvec - (tvec % 4);
`ifdef VECTORED_MTVEC_EN
        if ((tvec % 4) == 1 && cause[31]) return base + 4 * (cause & 32'h7FFF_FFFF);
`endif
        return base;
    endfunction

    task automatic clear_inputs();
        bus.csr_w = 0; bus.csr_wsc_mode = 2'b00; bus.csr_raddr = '0; bus.csr_waddr = '0;
        bus.csr_wdata = '0; bus.trap_req = 0; bus.trap_cause = '0; bus.trap_epc = '0;
        bus.trap_tval = '0; bus.mret_req = 0; bus.irq_ext = 0; bus.instret_inc = 0;
        bus.redirect_ack = 0;
    endtask

    task automatic model_reset();
        m_mie_b = 0; m_mpie_b = 0; m_irqp = 0; m_mie = 0; m_mtvec = MTVEC_RST & M_TVEC_MASK;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
        m_busy = 0;
    endtask

    // Advance the model across one clock edge using the currently driven inputs, then step the DUT.
    task automatic tick();
        logic        nxt_irqp;
        logic [31:0] nv, old;
        bit          cyc_w, ins_w;
        nxt_irqp = m_mie_b & m_mie[11] & bus.irq_ext;
        cyc_w = 0; ins_w = 0;
        if (!rst) begin
            if (m_busy) begin
                if (bus.redirect_ack) m_busy = 0;
            end else if (bus.trap_req) begin
                pc_q.push_back(m_trap_target(m_mtvec, bus.trap_cause));
                m_mepc = bus.trap_epc & ~32'h3; m_mcause = bus.trap_cause; m_mtval = bus.trap_tval;
                m_mpie_b = m_mie_b; m_mie_b = 0; m_busy = 1;
            end else if (bus.mret_req) begin
                pc_q.push_back(m_mepc);
                m_mie_b = m_mpie_b; m_mpie_b = 1; m_busy = 1;
            end else if (bus.csr_w && bus.csr_wsc_mode != 2'b00 && m_writable(bus.csr_waddr)) begin
                old = m_read(bus.csr_waddr);
                case (bus.csr_wsc_mode)
                    2'b01:   nv = bus.csr_wdata;
                    2'b10:   nv = old | bus.csr_wdata;
                    default: nv = old & ~bus.csr_wdata;
                endcase
                case (bus.csr_waddr)
                    12'h300: begin m_mie_b = nv[3]; m_mpie_b = nv[7]; end
                    12'h304: m_mie = nv & 32'h0000_0888;
                    12'h305: m_mtvec = nv & M_TVEC_MASK;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    12'hB00: begin m_mcycle[31:0] = nv; cyc_w = 1; end
                    12'hB80: begin m_mcycle[63:32] = nv; cyc_w = 1; end
                    12'hB02: begin m_minstret[31:0] = nv; ins_w = 1; end
                    default: begin m_minstret[63:32] = nv; ins_w = 1; end
                endcase
            end
            if (!cyc_w) m_mcycle = m_mcycle + 64'd1;
            if (!ins_w && bus.instret_inc) m_minstret = m_minstret + 64'd1;
        end
        @(posedge clk);
        m_irqp = rst ? 1'b0 : nxt_irqp;
        #1;
        if (!rst && !m_busy) begin
            check("irq_pending", 32'(bus.irq_pending), 32'(m_irqp));
            check("mstatus_out", bus.mstatus_out, m_mstatus());
            check("busy_idle", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic rd_push(input logic [11:0] a, input logic [31:0] exp);
        bus.csr_raddr = a;
        rd_addr_q.push_back(a);
        rd_exp_q.push_back(exp);
        rd_chk = 1;
        tick();
        rd_chk = 0;
    endtask

    task automatic rd(input logic [11:0] a);
        rd_push(a, m_read(a));
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] mode, input logic [31:0] d);
        bus.csr_w = 1; bus.csr_wsc_mode = mode; bus.csr_waddr = a; bus.csr_wdata = d;
        tick();
        bus.csr_w = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        rd_chk = 0;
        clear_inputs();
        model_reset();
        pc_q.delete();
        tick();
        tick();
        rst = 0;
    endtask

    // Caller has raised trap_req and/or mret_req; runs the request through to the acked redirect.
    task automatic run_redirect(input int hold, input bit junk);
        int lat;
        tick();
        lat = 1;
        bus.trap_req = 0; bus.mret_req = 0;
        while (!bus.redirect_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("redirect_latency", 32'(lat), 32'd2);
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                bus.trap_req = 1; bus.trap_cause = $urandom; bus.trap_epc = $urandom;
                bus.mret_req = 1;
                bus.csr_w = 1; bus.csr_wsc_mode = 2'b01; bus.csr_waddr = 12'h340; bus.csr_wdata = $urandom;
            end
            tick();
            check("hold_valid", 32'(bus.redirect_valid), 32'd1);
            check("hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.trap_req = 0; bus.mret_req = 0; bus.csr_w = 0;
        bus.redirect_ack = 1;
        tick();
        bus.redirect_ack = 0;
        check("post_ack_valid", 32'(bus.redirect_valid), 32'd0);
    endtask

    task automatic trap(input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] tval,
                        input int hold, input bit junk);
        bus.trap_req = 1; bus.trap_cause = cause; bus.trap_epc = epc; bus.trap_tval = tval;
        run_redirect(hold, junk);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read or a redirect handshake.
    always @(negedge clk) begin
        if (rd_chk) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL csr_read: actual=%08h required=<no expectation queued>", bus.csr_rdata);
            end else begin
                mon_addr = rd_addr_q.pop_front();
                mon_exp  = rd_exp_q.pop_front();
                check($sformatf("csr_rd_%03h", mon_addr), bus.csr_rdata, mon_exp);
            end
        end
        if (!rst && bus.redirect_valid && bus.redirect_ack) begin
            last_redirect_pc = bus.redirect_pc;
            if (pc_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL redirect_pc: actual=%08h required=<no redirect expected>", bus.redirect_pc);
            end else begin
                check("redirect_pc", bus.redirect_pc, pc_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] probe_a [5] = '{12'h301, 12'h344, 12'h7C0, 12'h340, 12'hB00};
        logic        probe_e [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int r;

        do_reset();
        check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_irq_pending", 32'(bus.irq_pending), 32'd0);
        check("rst_mstatus_out", bus.mstatus_out, 32'h0000_1800);
        rd_push(12'h300, 32'h0000_1800);
        rd_push(12'h305, MTVEC_RST);
        rd_push(12'h301, 32'h4000_0100);
        rd_push(12'h341, 32'h0);
        rd_push(12'h7C0, 32'h0);

        // illegal-access decode
        for (int i = 0; i < 5; i++) begin
            bus.csr_w = 1; bus.csr_wsc_mode = 2'b01; bus.csr_waddr = probe_a[i]; bus.csr_wdata = $urandom;
            #1;
            check($sformatf("illegal_%03h", probe_a[i]), 32'(bus.csr_illegal), 32'(probe_e[i]));
            tick();
        end
        bus.csr_w = 0; bus.csr_waddr = 12'h7C0;
        #1;
        check("illegal_no_csr_w", 32'(bus.csr_illegal), 32'd0);
        rd_push(12'h301, 32'h4000_0100);
        rd(12'hB00);

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            bus.irq_ext = 1'($urandom_range(0, 1));
            bus.instret_inc = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 11);
            if (r == 0) begin
                trap({1'($urandom_range(0, 1)), 31'($urandom_range(0, 15))}, $urandom, $urandom,
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end else if (r == 1) begin
                bus.mret_req = 1;
                run_redirect($urandom_range(0, 2), 0);
            end else begin
                bus.csr_w = 1'($urandom_range(0, 3) != 0);
                bus.csr_wsc_mode = 2'($urandom_range(0, 3));
                bus.csr_waddr = wlist[$urandom_range(0, 11)];
                bus.csr_wdata = (bus.csr_waddr == 12'hB80 || bus.csr_waddr == 12'hB82) ? 32'($urandom_range(0, 3)) : $urandom;
                rd(rlist[$urandom_range(0, 15)]);
                bus.csr_w = 0;
            end
        end
        bus.irq_ext = 0; bus.instret_inc = 0;

        // directed trap entry with a held redirect and ignored requests while busy
        wr(12'h300, 2'b01, 32'h0000_0008);
        wr(12'h304, 2'b01, 32'h0000_0000);
        wr(12'h305, 2'b01, 32'h0000_0200);
        wr(12'h340, 2'b01, 32'h1234_5678);
        trap(32'd2, 32'h0000_1006, 32'h0000_DEAD, 3, 1);
        check("trap_pc_const", last_redirect_pc, 32'h0000_0200);
        rd_push(12'h341, 32'h0000_1004);
        rd_push(12'h342, 32'h0000_0002);
        rd_push(12'h343, 32'h0000_DEAD);
        rd_push(12'h300, 32'h0000_1880);
        rd_push(12'h340, 32'h1234_5678);

        // MRET back
        bus.mret_req = 1;
        run_redirect(0, 0);
        check("mret_pc_const", last_redirect_pc, 32'h0000_1004);
        rd_push(12'h300, 32'h0000_1888);

        // 64-bit counter wrap via CSR writes
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
        tick();
        rd_push(12'hB00, 32'h0);
        rd_push(12'hB80, 32'h0);
        bus.instret_inc = 1;
        wr(12'hB02, 2'b01, 32'hFFFF_FFFF);
        wr(12'hB82, 2'b01, 32'hFFFF_FFFF);
        tick();
        bus.instret_inc = 0;
        rd_push(12'hB02, 32'h0);
        rd_push(12'hB82, 32'h0);

        // simultaneous trap and MRET: trap wins
        bus.mret_req = 1;
        trap(32'd7, 32'h0000_2000, 32'h0, 1, 0);
        check("simul_trap_pc", last_redirect_pc, 32'h0000_0200);
        rd_push(12'h342, 32'd7);
        rd_push(12'h341, 32'h0000_2000);

        // interrupt trap with mtvec mode bits set
        wr(12'h305, 2'b01, 32'h0000_0101);
`ifdef VECTORED_MTVEC_EN
        rd_push(12'h305, 32'h0000_0101);
        trap(32'h8000_000B, 32'h0000_3000, 32'h0, 0, 0);
        check("vec_irq_pc", last_redirect_pc, 32'h0000_012C);
        trap(32'd2, 32'h0000_3000, 32'h0, 0, 0);
        check("vec_exc_pc", last_redirect_pc, 32'h0000_0100);
`else
        rd_push(12'h305, 32'h0000_0100);
        trap(32'h8000_000B, 32'h0000_3000, 32'h0, 0, 0);
        check("direct_irq_pc", last_redirect_pc, 32'h0000_0100);
`endif

        // reset in the middle of a trap sequence
        bus.trap_req = 1; bus.trap_cause = 32'd5; bus.trap_epc = 32'h0000_4444; bus.trap_tval = 32'h55;
        tick();
        bus.trap_req = 0;
        tick();
        rst = 1;
        #1;
        check("midrst_valid", 32'(bus.redirect_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_mstatus", bus.mstatus_out, 32'h0000_1800);
        do_reset();
        rd_push(12'h341, 32'h0);
        rd_push(12'h342, 32'h0);
        rd_push(12'h305, MTVEC_RST);
        tick();

        check("pc_queue_drained", 32'(pc_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
